ft_checkpoint_mem: RTL and testbench

Parametrised, double-buffered checkpoint store for the fault-tolerant core. Register-file writebacks and PC loads land in a per-entry working copy. `commit_i` promotes every dirty entry to the committed copy in one cycle, and `rollback_i` discards uncommitted updates. Committed state is readable over the req/gnt/rvalid data-memory port, or can be streamed out in index order by a restore sequencer for core recovery.

---
 rtl/ft_checkpoint_mem_if.sv | 22 ++
 rtl/ft_checkpoint_mem.sv | 166 ++++++++++++++++
 tb/tb_ft_checkpoint_mem.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft_checkpoint_mem_if.sv
// Committed-state read port of the checkpoint store: req/gnt handshake with a
// one-cycle registered response.
interface ft_checkpoint_mem_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  req_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [31:0]           addr_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;

  modport slave (
    input  req_i, addr_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

  modport master (
    output req_i, addr_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/ft_checkpoint_mem.sv
// Double-buffered register/PC checkpoint store: per-entry working and committed
// banks, single-cycle commit/rollback, committed read port and restore streamer.
module ft_checkpoint_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int REG_AW     = $clog2(NUM_REGS),
  parameter int IDX_W      = $clog2(NUM_REGS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_rf_i,
  input  logic [REG_AW-1:0]     addr_rf_i,
  input  logic [DATA_WIDTH-1:0] data_rf_i,
  input  logic                  load_pc_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  commit_i,
  input  logic                  rollback_i,
  input  logic                  restore_i,
  output logic                  restore_busy_o,
  output logic                  restore_valid_o,
  output logic [IDX_W-1:0]      restore_idx_o,
  output logic [DATA_WIDTH-1:0] restore_data_o,
  output logic                  dirty_o,
  ft_checkpoint_mem_if.slave    rd
);

  localparam int NUM_ENT = NUM_REGS + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_reg;
  logic                    busy_reg;
  logic                    beat_valid_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [DATA_WIDTH-1:0]   beat_data_reg;

  logic                    commit_eff;
  logic                    rollback_eff;
  logic [NUM_ENT-1:0]      dirty_vec;
  logic [DATA_WIDTH-1:0]   committed [NUM_ENT];

  // The streamer freezes committed state so the beats form a consistent snapshot.
  assign rollback_eff = rollback_i & (state_reg == IDLE);
  assign commit_eff   = commit_i & ~rollback_i & (state_reg == IDLE);

  for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_entry
    logic                  sel_reg;
    logic                  dirty_reg;
    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] bank0_reg;
    logic [DATA_WIDTH-1:0] bank1_reg;
    logic                  wr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  promote;
    logic                  sel_next;

    if (gi < NUM_REGS) begin : g_reg
      assign wr    = we_rf_i && (addr_rf_i == REG_AW'(gi));
      assign wdata = data_rf_i;
    end else begin : g_pc
      assign wr    = load_pc_i;
      assign wdata = pc_i;
    end

    assign promote  = commit_eff & dirty_reg;
    assign sel_next = sel_reg ^ promote;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sel_reg   <= 1'b0;
        dirty_reg <= 1'b0;
        valid_reg <= 1'b0;
      end else begin
        sel_reg   <= sel_next;
        valid_reg <= valid_reg | promote;
        dirty_reg <= wr | (dirty_reg & ~commit_eff & ~rollback_eff);
      end
    end

    // A same-cycle write lands in the bank that is working after the commit.
    always_ff @(posedge clk_i) begin
      if (wr) begin
        if (sel_next) bank0_reg <= wdata;
        else          bank1_reg <= wdata;
      end
    end

    assign dirty_vec[gi] = dirty_reg;
    assign committed[gi] = valid_reg ? (sel_reg ? bank1_reg : bank0_reg) : '0;
  end

  assign dirty_o = |dirty_vec;

  logic [29:0]           word_idx;
  logic                  rd_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  gnt;
  logic                  rvalid_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  assign word_idx = rd.addr_i[31:2];
  assign rd_err   = (rd.addr_i[1:0] != 2'b00) || (word_idx > 30'(NUM_REGS));
  assign rd_data  = rd_err ? '0 : committed[word_idx[IDX_W-1:0]];
  assign gnt      = rd.req_i & ~busy_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= gnt;
      if (gnt) begin
        err_reg   <= rd_err;
        rdata_reg <= rd_data;
      end
    end
  end

  assign rd.gnt_o    = gnt;
  assign rd.rvalid_o = rvalid_reg;
  assign rd.err_o    = err_reg;
  assign rd.rdata_o  = rdata_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      beat_valid_reg <= 1'b0;
      idx_reg        <= '0;
      beat_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (restore_i) begin
            state_reg      <= STREAM;
            busy_reg       <= 1'b1;
            beat_valid_reg <= 1'b1;
            idx_reg        <= '0;
            beat_data_reg  <= committed[0];
          end
        end
        STREAM: begin
          if (idx_reg == IDX_W'(NUM_REGS)) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            beat_valid_reg <= 1'b0;
            idx_reg        <= '0;
            beat_data_reg  <= '0;
          end else begin
            idx_reg       <= idx_reg + IDX_W'(1);
            beat_data_reg <= committed[idx_reg + IDX_W'(1)];
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign restore_busy_o  = busy_reg;
  assign restore_valid_o = beat_valid_reg;
  assign restore_idx_o   = idx_reg;
  assign restore_data_o  = beat_data_reg;

endmodule

// File: tb/tb_ft_checkpoint_mem.sv
// Self-checking bench for ft_checkpoint_mem: read responses are scored against
// a queue of expected values; each scenario task checks its own side outputs.
module tb_ft_checkpoint_mem;

  localparam int DW = 32;
  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_rf = 1'b0;
  logic [4:0]  addr_rf = '0;
  logic [31:0] data_rf = '0;
  logic        load_pc = 1'b0;
  logic [31:0] pc = '0;
  logic        commit = 1'b0;
  logic        rollback = 1'b0;
  logic        restore = 1'b0;
  logic        r_busy;
  logic        r_valid;
  logic [5:0]  r_idx;
  logic [31:0] r_data;
  logic        dirty;

  ft_checkpoint_mem_if #(.DATA_WIDTH(DW)) bus ();

  ft_checkpoint_mem #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .we_rf_i         (we_rf),
    .addr_rf_i       (addr_rf),
    .data_rf_i       (data_rf),
    .load_pc_i       (load_pc),
    .pc_i            (pc),
    .commit_i        (commit),
    .rollback_i      (rollback),
    .restore_i       (restore),
    .restore_busy_o  (r_busy),
    .restore_valid_o (r_valid),
    .restore_idx_o   (r_idx),
    .restore_data_o  (r_data),
    .dirty_o         (dirty),
    .rd              (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;

  // Scoreboard: every response is matched against the oldest expected read.
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.rvalid_o) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL rsp_unexpected: got data=%h err=%b, required no response",
                 bus.rdata_o, bus.err_o);
      end else begin
        mon_e = q.pop_front();
        if ({bus.err_o, bus.rdata_o} !== {mon_e.err, mon_e.data})
          $display("FAIL rsp: got data=%h err=%b, required data=%h err=%b",
                   bus.rdata_o, bus.err_o, mon_e.data, mon_e.err);
        else begin
          passed++;
          $display("read  data=%h err=%b ok", bus.rdata_o, bus.err_o);
        end
      end
    end
  end

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic e);
    exp_t x;
    x.err  = e;
    x.data = d;
    bus.req_i  = 1'b1;
    bus.addr_i = a;
    q.push_back(x);
    @(negedge clk);
    bus.req_i = 1'b0;
  endtask

  task automatic wr_rf(input int a, input logic [31:0] d);
    we_rf   = 1'b1;
    addr_rf = a[4:0];
    data_rf = d;
    @(negedge clk);
    we_rf = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0)
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, q.size());
    else
      passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_i  = 1'b0;
    bus.addr_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({r_busy, r_valid, r_idx, r_data, bus.rvalid_o, bus.err_o, bus.rdata_o, dirty, bus.gnt_o} !== '0)
      $display("FAIL reset_outputs: got busy=%b valid=%b idx=%0d rvalid=%b dirty=%b gnt=%b, required all 0",
               r_busy, r_valid, r_idx, bus.rvalid_o, dirty, bus.gnt_o);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    rd(32'h08, 32'h0, 1'b0);
    wait_drain("reset");
    checks++;
    if (dirty !== 1'b0) $display("FAIL reset_dirty: got %b, required 0", dirty);
    else passed++;
    $display("test_reset done");
  endtask

  task automatic test_write_commit();
    we_rf = 1'b1; addr_rf = 5'd5; data_rf = 32'hDEADBEEF;
    load_pc = 1'b1; pc = 32'h80;
    @(negedge clk);
    we_rf = 1'b0; load_pc = 1'b0;
    checks++;
    if (dirty !== 1'b1) $display("FAIL wc_dirty_set: got %b, required 1", dirty);
    else passed++;
    rd(32'h14, 32'h0, 1'b0);
    pulse_commit();
    checks++;
    if (dirty !== 1'b0) $display("FAIL wc_dirty_clear: got %b, required 0", dirty);
    else passed++;
    rd(32'h14, 32'hDEADBEEF, 1'b0);
    rd(32'h80, 32'h80, 1'b0);
    wait_drain("write_commit");
    $display("test_write_commit done");
  endtask

  task automatic test_rollback();
    wr_rf(3, 32'h11);
    pulse_commit();
    wr_rf(3, 32'h22);
    rollback = 1'b1;
    @(negedge clk);
    rollback = 1'b0;
    checks++;
    if (dirty !== 1'b0) $display("FAIL rb_dirty: got %b, required 0", dirty);
    else passed++;
    rd(32'h0C, 32'h11, 1'b0);
    pulse_commit();
    rd(32'h0C, 32'h11, 1'b0);
    wait_drain("rollback");
    $display("test_rollback done");
  endtask

  task automatic test_simultaneous();
    wr_rf(3, 32'h22);
    commit = 1'b1;
    we_rf = 1'b1; addr_rf = 5'd3; data_rf = 32'h33;
    @(negedge clk);
    commit = 1'b0; we_rf = 1'b0;
    checks++;
    if (dirty !== 1'b1) $display("FAIL sim_dirty: got %b, required 1", dirty);
    else passed++;
    rd(32'h0C, 32'h22, 1'b0);
    pulse_commit();
    rd(32'h0C, 32'h33, 1'b0);
    wr_rf(3, 32'h44);
    commit = 1'b1; rollback = 1'b1;
    @(negedge clk);
    commit = 1'b0; rollback = 1'b0;
    checks++;
    if (dirty !== 1'b0) $display("FAIL sim_cr_dirty: got %b, required 0", dirty);
    else passed++;
    rd(32'h0C, 32'h33, 1'b0);
    pulse_commit();
    rd(32'h0C, 32'h33, 1'b0);
    wait_drain("simultaneous");
    $display("test_simultaneous done");
  endtask

  task automatic test_errors();
    rd(32'h85, 32'h0, 1'b1);
    rd(32'h84, 32'h0, 1'b1);
    rd(32'h02, 32'h0, 1'b1);
    rd(32'h1000, 32'h0, 1'b1);
    wait_drain("errors");
    $display("test_errors done");
  endtask

  task automatic test_back_to_back();
    rd(32'h14, 32'hDEADBEEF, 1'b0);
    rd(32'h0C, 32'h33, 1'b0);
    rd(32'h80, 32'h80, 1'b0);
    rd(32'h85, 32'h0, 1'b1);
    rd(32'h14, 32'hDEADBEEF, 1'b0);
    wait_drain("b2b");
    $display("test_back_to_back done");
  endtask

  task automatic test_restore();
    logic [31:0] exp_d;
    for (int i = 0; i < NR; i++) wr_rf(i, 32'(i * 4));
    load_pc = 1'b1; pc = 32'h100;
    @(negedge clk);
    load_pc = 1'b0;
    pulse_commit();
    restore = 1'b1;
    @(negedge clk);
    restore = 1'b0;
    for (int k = 0; k <= NR; k++) begin
      exp_d = (k < NR) ? 32'(k * 4) : 32'h100;
      checks++;
      if ({r_valid, r_busy, r_idx, r_data} !== {1'b1, 1'b1, 6'(k), exp_d})
        $display("FAIL beat%0d: got valid=%b busy=%b idx=%0d data=%h, required 1 1 %0d %h",
                 k, r_valid, r_busy, r_idx, r_data, k, exp_d);
      else begin
        passed++;
        $display("beat  idx=%0d data=%h ok", r_idx, r_data);
      end
      if (k == 3) restore = 1'b1;
      if (k == 4) restore = 1'b0;
      if (k == 5) begin we_rf = 1'b1; addr_rf = 5'd7; data_rf = 32'hABC; end
      if (k == 6) we_rf = 1'b0;
      if (k == 10) begin
        commit = 1'b1;
        bus.req_i = 1'b1;
        bus.addr_i = 32'h14;
        #1;
        checks++;
        if (bus.gnt_o !== 1'b0) $display("FAIL stream_gnt: got %b, required 0", bus.gnt_o);
        else passed++;
      end
      if (k == 11) begin commit = 1'b0; bus.req_i = 1'b0; end
      @(negedge clk);
    end
    checks++;
    if ({r_busy, r_valid} !== 2'b00)
      $display("FAIL stream_end: got busy=%b valid=%b, required 0 0", r_busy, r_valid);
    else passed++;
    @(negedge clk);
    checks++;
    if ({r_busy, dirty} !== 2'b01)
      $display("FAIL stream_after: got busy=%b dirty=%b, required 0 1", r_busy, dirty);
    else passed++;
    rd(32'h1C, 32'h1C, 1'b0);
    pulse_commit();
    rd(32'h1C, 32'hABC, 1'b0);
    rd(32'h80, 32'h100, 1'b0);
    wait_drain("restore");

    restore = 1'b1;
    @(negedge clk);
    restore = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r_busy, r_valid, r_idx} !== '0)
      $display("FAIL reset_mid_restore: got busy=%b valid=%b idx=%0d, required 0 0 0",
               r_busy, r_valid, r_idx);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(32'h1C, 32'h0, 1'b0);
    wait_drain("post_reset");
    $display("test_restore done");
  endtask

  initial begin
    bus.req_i  = 1'b0;
    bus.addr_i = '0;
    test_reset();
    test_write_commit();
    test_rollback();
    test_simultaneous();
    test_errors();
    test_back_to_back();
    test_restore();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
